multi_edge_detector: RTL and testbench

- Parametrised successor to the single-channel edge detector.
- N independent channels, each with:
  - input synchroniser;
  - debounce filter;
  - registered rise/fall pulses;
  - per-channel mode-qualified event;
  - sticky pending flag with write-1-to-clear.
- A summary interrupt covers all channels.
- Sits between asynchronous board/peripheral inputs and the control logic or register block.

---
 rtl/edge_det_pkg.sv | 9 +
 rtl/edge_det_chan.sv | 66 ++++++
 rtl/multi_edge_detector.sv | 99 +++++++++
 tb/tb_multi_edge_detector.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/edge_det_pkg.sv
// Shared encodings for the multi-channel edge detector.
package edge_det_pkg;
  localparam int MODE_W = 2;

  localparam logic [MODE_W-1:0] MODE_OFF  = 2'b00;
  localparam logic [MODE_W-1:0] MODE_RISE = 2'b01;
  localparam logic [MODE_W-1:0] MODE_FALL = 2'b10;
  localparam logic [MODE_W-1:0] MODE_BOTH = 2'b11;
endpackage

// File: rtl/edge_det_chan.sv
// One edge-detector channel: synchroniser, debounce filter, registered rise/fall pulses.
// rise_next/fall_next expose the pre-register pulses so the top can register qualified events alongside.
module edge_det_chan #(
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE    = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic sig_in,
  output logic rise_next,
  output logic fall_next,
  output logic rising_edge,
  output logic falling_edge
);
  localparam int CW = (DEBOUNCE <= 1) ? 1 : $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0] C_LAST = (DEBOUNCE <= 1) ? '0 : CW'(DEBOUNCE - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   f_q, f_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   s;

  assign s = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], sig_in};
    f_d    = f_q;
    cnt_d  = cnt_q;
    if (DEBOUNCE <= 1) begin
      f_d   = s;
      cnt_d = '0;
    end else if (s == f_q) begin
      cnt_d = '0;
    end else if (cnt_q == C_LAST) begin
      f_d   = s;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
    rise_d = f_d & ~f_q;
    fall_d = ~f_d & f_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      cnt_q  <= '0;
      f_q    <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      f_q    <= f_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign rise_next    = rise_d;
  assign fall_next    = fall_d;
  assign rising_edge  = rise_q;
  assign falling_edge = fall_q;
endmodule

// File: rtl/multi_edge_detector.sv
// N-channel edge detector with mode-qualified events, sticky pending flags and summary irq.
// Define EDGE_CNT_EN to build per-channel saturating event counters; otherwise evt_cnt is zero.
module multi_edge_detector
  import edge_det_pkg::*;
#(
  parameter int N           = 4,
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE    = 3,
  parameter int CNT_W       = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N-1:0]        signal,
  input  logic [MODE_W*N-1:0] mode,
  input  logic [N-1:0]        clr,
  output logic [N-1:0]        rising_edge,
  output logic [N-1:0]        falling_edge,
  output logic [N-1:0]        event_pulse,
  output logic [N-1:0]        pending,
  output logic                irq,
  output logic [N*CNT_W-1:0]  evt_cnt
);
  logic [N-1:0] rise_nx, fall_nx;
  logic [N-1:0] event_q, event_d;
  logic [N-1:0] pending_q, pending_d;

  for (genvar i = 0; i < N; i++) begin : g_chan
    edge_det_chan #(
      .SYNC_STAGES(SYNC_STAGES),
      .DEBOUNCE   (DEBOUNCE)
    ) u_chan (
      .clk         (clk),
      .rst         (rst),
      .sig_in      (signal[i]),
      .rise_next   (rise_nx[i]),
      .fall_next   (fall_nx[i]),
      .rising_edge (rising_edge[i]),
      .falling_edge(falling_edge[i])
    );
  end

  // Set takes priority over clear so an event landing with clr is never lost.
  always_comb begin
    event_d   = '0;
    pending_d = '0;
    for (int i = 0; i < N; i++) begin
      logic [MODE_W-1:0] md;
      md = mode[MODE_W*i +: MODE_W];
      event_d[i] = (rise_nx[i] & ((md == MODE_RISE) | (md == MODE_BOTH)))
                 | (fall_nx[i] & ((md == MODE_FALL) | (md == MODE_BOTH)));
      pending_d[i] = event_q[i] | (pending_q[i] & ~clr[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      event_q   <= '0;
      pending_q <= '0;
    end else begin
      event_q   <= event_d;
      pending_q <= pending_d;
    end
  end

  assign event_pulse = event_q;
  assign pending     = pending_q;
  assign irq         = |pending_q;

`ifdef EDGE_CNT_EN
  logic [CNT_W-1:0] cnt_q [N];
  logic [CNT_W-1:0] cnt_d [N];

  always_comb begin
    for (int i = 0; i < N; i++) begin
      cnt_d[i] = cnt_q[i];
      if (clr[i]) begin
        cnt_d[i] = event_q[i] ? CNT_W'(1) : '0;
      end else if (event_q[i] && (cnt_q[i] != '1)) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  always_comb begin
    evt_cnt = '0;
    for (int i = 0; i < N; i++) evt_cnt[i*CNT_W +: CNT_W] = cnt_q[i];
  end
`else
  assign evt_cnt = '0;
`endif
endmodule

// File: tb/tb_multi_edge_detector.sv
// Directed bench for multi_edge_detector: N=4, SYNC_STAGES=2, DEBOUNCE=3, CNT_W=2.
module tb_multi_edge_detector;
  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] signal;
  logic [7:0] mode;
  logic [3:0] clr;
  logic [3:0] rising_edge, falling_edge, event_pulse, pending;
  logic       irq;
  logic [7:0] evt_cnt;

  int total = 0;
  int bad   = 0;

`ifdef EDGE_CNT_EN
  localparam logic [7:0] CNT_SAT  = 8'h0C;
  localparam logic [7:0] CNT_RACE = 8'h04;
`else
  localparam logic [7:0] CNT_SAT  = 8'h00;
  localparam logic [7:0] CNT_RACE = 8'h00;
`endif

  multi_edge_detector #(
    .N(4), .SYNC_STAGES(2), .DEBOUNCE(3), .CNT_W(2)
  ) dut (
    .clk(clk), .rst(rst), .signal(signal), .mode(mode), .clr(clr),
    .rising_edge(rising_edge), .falling_edge(falling_edge),
    .event_pulse(event_pulse), .pending(pending), .irq(irq), .evt_cnt(evt_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst    = 1'b1;
    signal = 4'hF;
    mode   = 8'b11_10_01_00;
    clr    = 4'h0;

    // reset held with all inputs high
    tick(3);
    chk("rst_rise", rising_edge, 4'h0);
    chk("rst_fall", falling_edge, 4'h0);
    chk("rst_evt", event_pulse, 4'h0);
    chk("rst_pend", pending, 4'h0);
    chk("rst_irq", irq, 1'b0);
    chk("rst_cnt", evt_cnt, 8'h00);
    rst = 1'b0;
    tick(4);
    chk("rel_rise_early", rising_edge, 4'h0);
    tick(1);
    chk("rel_rise", rising_edge, 4'hF);
    chk("rel_fall", falling_edge, 4'h0);
    chk("rel_evt", event_pulse, 4'hA);
    tick(1);
    chk("rel_rise_gone", rising_edge, 4'h0);
    chk("rel_pend", pending, 4'hA);
    chk("rel_irq", irq, 1'b1);

    // latency on ch1 from a clean reset
    rst = 1'b1;
    signal = 4'h0;
    tick(2);
    rst = 1'b0;
    tick(2);
    chk("lat_pend0", pending, 4'h0);
    chk("lat_irq0", irq, 1'b0);
    signal = 4'h2;
    tick(4);
    chk("lat_rise_early", rising_edge, 4'h0);
    tick(1);
    chk("lat_rise", rising_edge, 4'h2);
    chk("lat_evt", event_pulse, 4'h2);
    tick(1);
    chk("lat_rise_gone", rising_edge, 4'h0);
    chk("lat_evt_gone", event_pulse, 4'h0);
    chk("lat_pend", pending, 4'h2);

    // two-cycle glitch on ch3 must be filtered
    signal = 4'hA;
    tick(2);
    signal = 4'h2;
    for (int k = 0; k < 8; k++) begin
      tick(1);
      chk("glitch_edges", {rising_edge, falling_edge}, 8'h00);
    end
    chk("glitch_pend", pending, 4'h2);

    // accept ch2 and ch3 high; ch2 is fall-only so only ch3 fires
    signal = 4'hE;
    tick(4);
    chk("up23_early", rising_edge, 4'h0);
    tick(1);
    chk("up23_rise", rising_edge, 4'hC);
    chk("up23_evt", event_pulse, 4'h8);
    tick(1);
    chk("up23_pend", pending, 4'hA);

    // drop ch2/ch3, clr ch3 in the event cycle then once more
    signal = 4'h2;
    tick(5);
    chk("dn23_fall", falling_edge, 4'hC);
    chk("dn23_rise", rising_edge, 4'h0);
    chk("dn23_evt", event_pulse, 4'hC);
    clr = 4'h8;
    tick(1);
    clr = 4'h0;
    chk("race_pend", pending, 4'hE);
    clr = 4'h8;
    tick(1);
    clr = 4'h0;
    chk("clr_pend", pending, 4'h6);
    chk("clr_irq", irq, 1'b1);

    // ch0 mode off: raw edges pulse, nothing qualifies
    signal = 4'h3;
    tick(5);
    chk("off_rise", rising_edge, 4'h1);
    chk("off_evt_r", event_pulse, 4'h0);
    tick(5);
    signal = 4'h2;
    tick(5);
    chk("off_fall", falling_edge, 4'h1);
    chk("off_evt_f", event_pulse, 4'h0);
    tick(5);
    chk("off_pend", pending, 4'h6);

    // counters: clear all, then repeated qualified rises on ch1
    clr = 4'hF;
    tick(1);
    clr = 4'h0;
    chk("cnt_clr_pend", pending, 4'h0);
    chk("cnt_clr_irq", irq, 1'b0);
    chk("cnt_clr", evt_cnt, 8'h00);
    for (int k = 1; k <= 5; k++) begin
      signal = 4'h0;
      tick(6);
      signal = 4'h2;
      tick(6);
      if (k == 3) chk("cnt_three", evt_cnt, CNT_SAT);
    end
    chk("cnt_sat", evt_cnt, CNT_SAT);
    chk("cnt_pend", pending, 4'h2);
    signal = 4'h0;
    tick(6);
    signal = 4'h2;
    tick(5);
    chk("cnt6_evt", event_pulse, 4'h2);
    clr = 4'h2;
    tick(1);
    clr = 4'h0;
    chk("cnt_race", evt_cnt, CNT_RACE);
    chk("cnt_race_pend", pending, 4'h2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
